// File: rtl/trap_unit_if.sv
// Trap unit bus: trap/MRET requests, fetch redirect, and the CSR file port.
interface trap_unit_if;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_req;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_read;
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_data;

    // Trap unit side
    modport slave (
        input  trap_req, trap_pc, trap_cause, mret_req, csr_read_data,
        output busy, redirect_valid, redirect_pc,
        output csr_read, csr_write, csr_addr, csr_write_data
    );

    // Core / CSR file side
    modport master (
        output trap_req, trap_pc, trap_cause, mret_req, csr_read_data,
        input  busy, redirect_valid, redirect_pc,
        input  csr_read, csr_write, csr_addr, csr_write_data
    );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap entry / MRET sequencer. Walks the CSR file one access
// per cycle, then emits a single-cycle fetch redirect.
module trap_unit #(
    parameter int unsigned VECTORED_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    trap_unit_if.slave bus
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam int          MIE_BIT     = 3;
    localparam int          MPIE_BIT    = 7;

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, T_STATUS, R_TVEC, R_EPC, M_STATUS, DONE
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_target;
    logic [31:0] r_pc;
    logic [31:0] r_cause;

    logic        w_csr_read;
    logic        w_csr_write;
    logic [11:0] w_csr_addr;
    logic [31:0] w_csr_wdata;
    logic [31:0] w_tvec_base;
    logic [31:0] w_tvec_target;
    logic        w_vectored;

    // MTVEC decode: vectored offset only for interrupts in mode 01
    always_comb begin
        w_tvec_base   = {bus.csr_read_data[31:2], 2'b00};
        w_vectored    = (VECTORED_EN != 0) && (bus.csr_read_data[1:0] == 2'b01) && r_cause[31];
        w_tvec_target = w_vectored ? (w_tvec_base + {r_cause[29:0], 2'b00}) : w_tvec_base;
    end

    // CSR port decoded from state; MSTATUS updates are same-cycle read-modify-write
    always_comb begin
        w_csr_read  = 1'b0;
        w_csr_write = 1'b0;
        w_csr_addr  = 12'h000;
        w_csr_wdata = 32'h0;
        case (r_state)
            W_EPC: begin
                w_csr_write = 1'b1;
                w_csr_addr  = CSR_MEPC;
                w_csr_wdata = {r_pc[31:2], 2'b00};
            end
            W_CAUSE: begin
                w_csr_write = 1'b1;
                w_csr_addr  = CSR_MCAUSE;
                w_csr_wdata = r_cause;
            end
            T_STATUS: begin
                w_csr_read            = 1'b1;
                w_csr_write           = 1'b1;
                w_csr_addr            = CSR_MSTATUS;
                w_csr_wdata           = bus.csr_read_data;
                w_csr_wdata[MPIE_BIT] = bus.csr_read_data[MIE_BIT];
                w_csr_wdata[MIE_BIT]  = 1'b0;
                w_csr_wdata[12:11]    = 2'b11;
            end
            R_TVEC: begin
                w_csr_read = 1'b1;
                w_csr_addr = CSR_MTVEC;
            end
            R_EPC: begin
                w_csr_read = 1'b1;
                w_csr_addr = CSR_MEPC;
            end
            M_STATUS: begin
                w_csr_read            = 1'b1;
                w_csr_write           = 1'b1;
                w_csr_addr            = CSR_MSTATUS;
                w_csr_wdata           = bus.csr_read_data;
                w_csr_wdata[MIE_BIT]  = bus.csr_read_data[MPIE_BIT];
                w_csr_wdata[MPIE_BIT] = 1'b1;
                w_csr_wdata[12:11]    = 2'b11;
            end
            default: ;
        endcase
    end

    // Sequencer with registered busy/redirect outputs; redirect_pc only moves on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_busy           <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0;
            r_target         <= 32'h0;
            r_pc             <= 32'h0;
            r_cause          <= 32'h0;
        end else begin
            r_redirect_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.trap_req) begin
                        r_pc    <= bus.trap_pc;
                        r_cause <= bus.trap_cause;
                        r_state <= W_EPC;
                        r_busy  <= 1'b1;
                    end else if (bus.mret_req) begin
                        r_state <= R_EPC;
                        r_busy  <= 1'b1;
                    end
                end
                W_EPC:    r_state <= W_CAUSE;
                W_CAUSE:  r_state <= T_STATUS;
                T_STATUS: r_state <= R_TVEC;
                R_TVEC: begin
                    r_redirect_pc    <= w_tvec_target;
                    r_redirect_valid <= 1'b1;
                    r_state          <= DONE;
                end
                R_EPC: begin
                    r_target <= {bus.csr_read_data[31:2], 2'b00};
                    r_state  <= M_STATUS;
                end
                M_STATUS: begin
                    r_redirect_pc    <= r_target;
                    r_redirect_valid <= 1'b1;
                    r_state          <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.csr_read       = w_csr_read;
    assign bus.csr_write      = w_csr_write;
    assign bus.csr_addr       = w_csr_addr;
    assign bus.csr_write_data = w_csr_wdata;

endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 The block SHALL have parameter VECTORED_EN, default 1, meaning vectored MTVEC mode is honoured for interrupts when 1 and forced to direct when 0.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 trap_req  input  1  trap request, sampled only in IDLE.
REQ-005 trap_pc  input  32  PC of the faulting or interrupted instruction.
REQ-006 trap_cause  input  32  mcause value; bit 31 is the interrupt flag, bits 30:0 are the code.
REQ-007 mret_req  input  1  MRET request, sampled only in IDLE.
REQ-008 busy  output  1  high in every non-IDLE state.
REQ-009 redirect_valid  output  1  one-cycle pulse qualifying redirect_pc.
REQ-010 redirect_pc  output  32  fetch redirect target.
REQ-011 csr_read, csr_write  output  1 each  CSR file port enables.
REQ-012 csr_addr  output  12  CSR address.
REQ-013 csr_write_data  output  32  CSR write data.
REQ-014 csr_read_data  input  32  combinational CSR read data, valid in the same cycle as csr_read.

Function
REQ-015 CSR addresses SHALL be MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342; MSTATUS fields SHALL be MIE bit 3, MPIE bit 7, MPP bits 12:11.
REQ-016 The FSM states SHALL be IDLE, W_EPC, W_CAUSE, T_STATUS, R_TVEC, R_EPC, M_STATUS, DONE.
REQ-017 In IDLE, trap_req=1 SHALL latch trap_pc and trap_cause and go to W_EPC; otherwise mret_req=1 SHALL go to R_EPC.
REQ-018 When trap_req and mret_req are both high in IDLE, the trap SHALL win and the MRET SHALL be dropped.
REQ-019 Requests arriving while busy=1 SHALL be ignored and not queued.
REQ-020 The trap sequence SHALL be W_EPC -> W_CAUSE -> T_STATUS -> R_TVEC -> DONE -> IDLE, one cycle per state.
REQ-021 With acceptance at edge N, redirect_valid SHALL be high in the cycle after edge N+4.
REQ-022 The MRET sequence SHALL be R_EPC -> M_STATUS -> DONE -> IDLE, so redirect_valid is high in the cycle after edge N+2.
REQ-023 W_EPC SHALL write MEPC with {trap_pc[31:2],2'b00}.
REQ-024 W_CAUSE SHALL write MCAUSE with the latched cause.
REQ-025 T_STATUS SHALL assert csr_read and csr_write together at MSTATUS, writing old value with MPIE=old MIE, MIE=0, MPP=2'b11, all other bits preserved; the CSR file's read-before-write ordering makes this a single-cycle read-modify-write.
REQ-026 M_STATUS SHALL perform the same single-cycle read-modify-write with MIE=old MPIE, MPIE=1, MPP=2'b11, other bits preserved.
REQ-027 R_TVEC SHALL read MTVEC and register the target: base={mtvec[31:2],2'b00}.
REQ-028 In R_TVEC, when mtvec[1:0]==2'b01, VECTORED_EN=1 and cause[31]=1, the target SHALL be base+{cause[29:0],2'b00}, modulo 2^32.
REQ-029 In R_TVEC, for any other mode value (including 2'b10 and 2'b11), the target SHALL be base.
REQ-030 R_EPC SHALL read MEPC and register {mepc[31:2],2'b00} as the target.
REQ-031 In DONE, redirect_valid=1 SHALL be driven for exactly one cycle, then the FSM SHALL return to IDLE; redirect_pc SHALL hold its last value until the next DONE.
REQ-032 CSR port outputs SHALL be decoded from state, and csr_read, csr_write, csr_addr and csr_write_data SHALL all be 0 in IDLE and DONE.
REQ-033 A new request SHALL be acceptable in the IDLE cycle immediately following DONE.

Reset
REQ-034 While rst_n=0, the FSM SHALL be IDLE and busy, redirect_valid, redirect_pc, all csr_* outputs and the latched trap_pc and cause SHALL all be 0, asynchronously.
REQ-035 Reset asserted mid-sequence SHALL abort without completing the remaining CSR writes, with no redirect_valid pulse; the first request after deassertion SHALL be handled normally.

Verification
REQ-036 Trap: MSTATUS=0x8, MTVEC=0x100, trap_pc=0x2006, cause=0x2 -> MEPC=0x2004, MCAUSE=0x2, MSTATUS=0x1880, redirect_pc=0x100, pulse 5 cycles after acceptance.
REQ-037 Vectored: MTVEC=0x101, cause=0x80000007 -> redirect_pc=0x11C; same case with VECTORED_EN=0 -> 0x100; cause=0x2 with MTVEC=0x101 -> 0x100.
REQ-038 MRET: MSTATUS=0x1880, MEPC=0x2004 -> MSTATUS=0x1888, redirect_pc=0x2004, pulse 3 cycles after acceptance.
REQ-039 Simultaneous trap_req and mret_req in IDLE -> trap sequence only; requests pulsed during busy -> no extra CSR accesses or redirect.
REQ-040 rst_n low during T_STATUS -> MSTATUS unchanged from pre-trap value (MEPC and MCAUSE already written), no redirect, all outputs 0.
REQ-041 Back-to-back: a trap completes and trap_req is high again on the first IDLE cycle -> second sequence starts immediately with correct CSR values.
